// File: rtl/hazard_stall_ctrl_if.sv
// Hazard unit signal bundle: decode/execute status in, pipeline control out.
// master drives the pipeline status, slave is the hazard unit.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] F_D_RS1;
  logic [REG_W-1:0] F_D_RS2;
  logic             F_D_isStore;
  logic             F_D_isMD;
  logic [REG_W-1:0] D_X_RD;
  logic             D_X_isLoad;
  logic             branchTaken;
  logic             mdReady;
  logic             stallPC;
  logic             stallFD;
  logic             bubbleDX;
  logic             flushFD;
  logic             mdStart;
  logic             mdAbort;
  logic             mdBusy;
  logic             mdError;
  logic [15:0]      stallCount;

  modport master (
    output F_D_RS1, F_D_RS2, F_D_isStore, F_D_isMD,
    output D_X_RD, D_X_isLoad, branchTaken, mdReady,
    input  stallPC, stallFD, bubbleDX, flushFD,
    input  mdStart, mdAbort, mdBusy, mdError, stallCount
  );

  modport slave (
    input  F_D_RS1, F_D_RS2, F_D_isStore, F_D_isMD,
    input  D_X_RD, D_X_isLoad, branchTaken, mdReady,
    output stallPC, stallFD, bubbleDX, flushFD,
    output mdStart, mdAbort, mdBusy, mdError, stallCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard unit: load-use stall, multdiv wait/abort, branch flush.
// Define HAZ_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int REG_W      = 5
) (
  input logic                clock,
  input logic                reset,
  hazard_stall_ctrl_if.slave hz
);

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] waitCnt_q, waitCnt_d;
  logic       mdError_q, mdError_d;

  logic loadUse;
  logic stall_c, bubble_c, flush_c;
  logic start_c, abort_c, busy_c;

  // Store data reaches M via the W->M bypass, so only address/ALU uses stall.
  assign loadUse = hz.D_X_isLoad && (hz.D_X_RD != '0) &&
                   ((hz.D_X_RD == hz.F_D_RS1) ||
                    ((hz.D_X_RD == hz.F_D_RS2) && !hz.F_D_isStore));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      waitCnt_q <= 8'd0;
      mdError_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      mdError_q <= mdError_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    mdError_d = mdError_q;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    start_c   = 1'b0;
    abort_c   = 1'b0;
    busy_c    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.branchTaken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (loadUse) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hz.F_D_isMD) begin
          start_c   = 1'b1;
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          state_d   = MD_WAIT;
          waitCnt_d = 8'd0;
        end
      end
      MD_WAIT: begin
        busy_c = 1'b1;
        if (hz.branchTaken) begin
          abort_c   = 1'b1;
          flush_c   = 1'b1;
          bubble_c  = 1'b1;
          state_d   = RUN;
          waitCnt_d = 8'd0;
        end else if (hz.mdReady) begin
          state_d   = RUN;
          waitCnt_d = 8'd0;
        end else if (waitCnt_q == WAIT_LAST) begin
          abort_c   = 1'b1;
          mdError_d = 1'b1;
          state_d   = RUN;
          waitCnt_d = 8'd0;
        end else begin
          stall_c   = 1'b1;
          bubble_c  = 1'b1;
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign hz.stallPC  = stall_c  && !reset;
  assign hz.stallFD  = stall_c  && !reset;
  assign hz.bubbleDX = bubble_c && !reset;
  assign hz.flushFD  = flush_c  && !reset;
  assign hz.mdStart  = start_c  && !reset;
  assign hz.mdAbort  = abort_c  && !reset;
  assign hz.mdBusy   = busy_c   && !reset;
  assign hz.mdError  = mdError_q && !reset;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stallCount_q, stallCount_d;

  always_comb begin
    stallCount_d = stallCount_q;
    if (hz.stallPC && (stallCount_q != 16'hFFFF))
      stallCount_d = stallCount_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stallCount_q <= 16'd0;
    else       stallCount_q <= stallCount_d;
  end

  assign hz.stallCount = stallCount_q;
`else
  assign hz.stallCount = 16'h0000;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Decode-stage hazard unit, upstream of the bypass controller.
- Resolves the hazards that forwarding cannot cover:
  - load-use dependencies;
  - multi-cycle mult/div occupancy;
  - taken-branch flushes.
- Drives PC/F-D hold, D-X bubble insertion, F-D flush and the multdiv start handshake.
- Whatever it lets through to D/X is handled by the bypass controller.

Parameters:
- MD_TIMEOUT, 64, max cycles in MD_WAIT before abort with error; range 2..255.
- REG_W, 5, register specifier width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- F_D_RS1  in  REG_W  rs1 of the instruction in F/D.
- F_D_RS2  in  REG_W  rs2 of the instruction in F/D.
- F_D_isStore  in  1  F/D instruction is a store; its RS2 is store data.
- F_D_isMD  in  1  F/D instruction is mult or div.
- D_X_RD  in  REG_W  destination of the instruction in D/X.
- D_X_isLoad  in  1  D/X instruction is a load.
- branchTaken  in  1  X stage resolved a taken branch or jump this cycle.
- mdReady  in  1  multdiv result valid; pulse.
- stallPC  out  1  hold the PC.
- stallFD  out  1  hold the F/D register.
- bubbleDX  out  1  load a nop into D/X.
- flushFD  out  1  load a nop into F/D.
- mdStart  out  1  one-cycle start pulse to multdiv.
- mdAbort  out  1  one-cycle abort pulse to multdiv.
- mdBusy  out  1  state is MD_WAIT.
- mdError  out  1  sticky timeout flag.
- stallCount  out  16  stall-cycle counter (optional feature).

Behaviour:
- States: RUN, MD_WAIT. Registered state: state, 8-bit waitCnt, mdError.
- Reset, asynchronous: state=RUN, waitCnt=0, mdError=0, stallCount=0.
- Combinational outputs are all 0 while reset is held.
- Load-use hazard, loadUse:
  - Requires D_X_isLoad=1 and D_X_RD!=0.
  - And either D_X_RD==F_D_RS1, or D_X_RD==F_D_RS2 with F_D_isStore=0.
  - Store-data dependence on a load is excluded; the W->M bypass covers it.
- Output priority within a cycle: branchTaken > MD_WAIT > loadUse > MD start.
- RUN state:
  - branchTaken=1: flushFD=1, bubbleDX=1, all stalls 0, mdStart suppressed, stay RUN.
  - Else if loadUse: stallPC=stallFD=bubbleDX=1, mdStart=0, stay RUN.
    - The stall lasts exactly one cycle, because the load moves to M next cycle.
  - Else if F_D_isMD: mdStart=1 this cycle, stallPC=stallFD=1, bubbleDX=1.
    - Next state MD_WAIT, waitCnt<=0.
  - Else: all outputs 0.
- MD_WAIT state:
  - mdBusy=1.
  - branchTaken=1: mdAbort=1, flushFD=1, bubbleDX=1, next RUN, waitCnt<=0.
  - Else if mdReady=1: all stalls 0 this cycle, so the MD instruction advances to D/X carrying the result. Next RUN.
  - Else if waitCnt==MD_TIMEOUT-1: mdAbort=1, mdError<=1, stalls 0, next RUN.
  - Else: stallPC=stallFD=bubbleDX=1, waitCnt<=waitCnt+1.
- mdReady received in RUN is ignored.
- mdStart is never asserted in MD_WAIT.
- mdError clears only on reset.
- Register 0 never creates a hazard.
- Reset mid-MD_WAIT returns to RUN with no mdAbort pulse; multdiv is reset by the same reset.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stallCount increments each cycle stallPC=1.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: stallCount tied to 16'h0000 and no counter flops are built.

Test Plan:
- Load-use on RS1: D_X_isLoad=1, D_X_RD=5, F_D_RS1=5 -> stallPC=stallFD=bubbleDX=1 for exactly 1 cycle, then 0 once D_X_isLoad=0.
- Store-data exemption: D_X_isLoad=1, D_X_RD=7, F_D_RS2=7, F_D_isStore=1, F_D_RS1=3 -> no stall. Same case with D_X_RD=0 and RS1=0 -> no stall.
- Mult/div: F_D_isMD=1 in RUN -> mdStart pulse 1 cycle, mdBusy=1, stalls held; mdReady after 17 cycles -> stalls drop that cycle, RUN next, mdError=0.
- Timeout: MD_TIMEOUT=8, mdReady never asserted -> stalls for 8 cycles total in MD_WAIT, mdAbort pulse, mdError=1 sticky, RUN.
- Flush priority: branchTaken=1 while in MD_WAIT with loadUse also true -> mdAbort=1, flushFD=1, bubbleDX=1, stallPC=0, RUN next.
- HAZ_PERF_CNT_EN defined: 3 load-use stalls plus a 10-cycle MD wait (1 start + 9 waiting) -> stallCount=13. Macro undefined -> stallCount=0. Async reset mid-wait -> all outputs 0 immediately.
